// File: rtl/button_conditioner.sv
// N-channel push-button front end: synchronise, debounce, press pulses and last-pressed index.
// Define BUTTON_CONDITIONER_REPEAT_EN to regenerate press pulses while a button stays held.
module button_conditioner #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  In,
  output logic [N-1:0]  level,
  output logic [N-1:0]  press,
  output logic [IW-1:0] last_idx,
  output logic          last_valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  s;
  logic [CW-1:0] cnt [N];
  logic [CW-1:0] cnt_nxt [N];
  logic [N-1:0]  level_nxt;
  logic [N-1:0]  rep_pulse;
  logic [N-1:0]  press_nxt;
  logic [IW-1:0] idx_nxt;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every register here, arrays included, is cleared by the async reset so no
  // stale debounce or repeat count survives a reset pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= In;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // NOTE: combinational next-state logic uses blocking assignments with defaults
  // first, so no latch is inferred; registers below use non-blocking only.
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      if (s[i] != level[i]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) level_nxt[i] = s[i];
        else                                    cnt_nxt[i]   = cnt[i] + CW'(1);
      end
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt [N];
  logic [RW-1:0] rcnt_nxt [N];
  logic [N-1:0]  rphase, rphase_nxt;

  // rphase=0 waits REPEAT_DELAY after the press, rphase=1 repeats every REPEAT_PERIOD.
  // Counting requires level to stay high across the edge, so no pulse coincides with a fall.
  always_comb begin
    rep_pulse  = '0;
    rphase_nxt = '0;
    for (int i = 0; i < N; i++) begin
      rcnt_nxt[i] = '0;
      if (level[i] && level_nxt[i]) begin
        rphase_nxt[i] = rphase[i];
        if (rcnt[i] == (rphase[i] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
          rep_pulse[i]  = 1'b1;
          rphase_nxt[i] = 1'b1;
        end else begin
          rcnt_nxt[i] = rcnt[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rphase <= '0;
      for (int i = 0; i < N; i++) rcnt[i] <= '0;
    end else begin
      rphase <= rphase_nxt;
      for (int i = 0; i < N; i++) rcnt[i] <= rcnt_nxt[i];
    end
  end
`else
  assign rep_pulse = '0;
`endif

  assign press_nxt = (level_nxt & ~level) | rep_pulse;

  // Descending scan so the lowest-numbered pressing channel wins.
  always_comb begin
    idx_nxt = last_idx;
    for (int i = N - 1; i >= 0; i--) begin
      if (press_nxt[i]) idx_nxt = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level      <= '0;
      press      <= '0;
      last_idx   <= '0;
      last_valid <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      level <= level_nxt;
      press <= press_nxt;
      for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
      if (|press_nxt) begin
        last_idx   <= idx_nxt;
        last_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at default parameters (N=4, 2 sync, 4 debounce).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] In;
  logic [3:0] level;
  logic [3:0] press;
  logic [1:0] last_idx;
  logic       last_valid;

  int tests  = 0;
  int failed = 0;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  button_conditioner #(
    .N(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .In(In), .level(level), .press(press),
    .last_idx(last_idx), .last_valid(last_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_press, exp_level;

    reset = 1'b0;
    In    = 4'b0000;
    tick(2);
    check("reset_level", level, 4'b0000);
    check("reset_press", press, 4'b0000);
    check("reset_valid", last_valid, 1'b0);
    check("reset_idx", last_idx, 2'd0);

    // Clean press on channel 0
    reset = 1'b1;
    In    = 4'b0001;
    tick(5);
    check("clean_level_e5", level, 4'b0000);
    tick(1);
    check("clean_level_e6", level, 4'b0001);
    check("clean_press_e6", press, 4'b0001);
    check("clean_idx_e6", last_idx, 2'd0);
    check("clean_valid_e6", last_valid, 1'b1);
    tick(1);
    check("clean_press_e7", press, 4'b0000);
    check("clean_level_e7", level, 4'b0001);

    // 3-cycle glitch on channel 2 must be rejected
    In = 4'b0101;
    tick(3);
    In = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("bounce_press", press, 4'b0000);
      check("bounce_level", level, 4'b0001);
    end

    // Channel 2 held long enough: single press
    In = 4'b0101;
    tick(5);
    check("hold2_level_e5", level, 4'b0001);
    tick(1);
    check("hold2_press_e6", press, 4'b0100);
    check("hold2_level_e6", level, 4'b0101);
    check("hold2_idx", last_idx, 2'd2);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("hold2_no_repress", press, 4'b0000);
    end

    // Release everything: no pulses, last_idx retained
    In = 4'b0000;
    tick(5);
    check("rel_level_e5", level, 4'b0101);
    tick(1);
    check("rel_level_e6", level, 4'b0000);
    check("rel_press", press, 4'b0000);
    check("rel_idx", last_idx, 2'd2);

    // Simultaneous press of channels 1 and 3
    In = 4'b1010;
    tick(6);
    check("simul_press", press, 4'b1010);
    check("simul_idx", last_idx, 2'd1);
    tick(1);
    check("simul_press_off", press, 4'b0000);
    check("simul_level", level, 4'b1010);

    // Release channel 1 only
    In = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("rel1_press", press, 4'b0000);
      check("rel1_level", level, (k < 6) ? 4'b1010 : 4'b1000);
    end
    check("rel1_idx", last_idx, 2'd1);

    // Reset mid-count on channel 3
    In = 4'b0000;
    tick(6);
    check("pre_rst_level", level, 4'b0000);
    In = 4'b1000;
    tick(4);
    reset = 1'b0;
    #1;
    check("midrst_level", level, 4'b0000);
    check("midrst_press", press, 4'b0000);
    check("midrst_idx", last_idx, 2'd0);
    check("midrst_valid", last_valid, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(5);
    check("postrst_level_e5", level, 4'b0000);
    check("postrst_press_e5", press, 4'b0000);
    tick(1);
    check("postrst_press_e6", press, 4'b1000);
    check("postrst_idx", last_idx, 2'd3);
    check("postrst_valid", last_valid, 1'b1);

    // Channel 0 held 40 cycles while channel 3 releases; repeats only with the macro
    In = 4'b0001;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (k == 40) In = 4'b0000;
      exp_press    = 4'b0000;
      exp_press[0] = (k == 6) || (REP && k >= 14 && k < 46 && ((k - 14) % 4) == 0);
      exp_level    = {(k < 6), 2'b00, (k >= 6 && k < 46)};
      check($sformatf("rep_press_k%0d", k), press, exp_press);
      check($sformatf("rep_level_k%0d", k), level, exp_level);
    end
    check("rep_idx", last_idx, 2'd0);
    check("rep_valid", last_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised N-channel user-input front end for the game controller: each asynchronous push-button input is synchronised, debounced and converted into a stable level plus a one-cycle press pulse. A shared register tracks the most recently pressed channel so the direction logic can read one index instead of N pulses. An optional hold-to-repeat mode regenerates press pulses while a button stays held.

## Interface

- `N`, 4: number of button channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flip-flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a changed value must persist before it is accepted (≥1).
- `REPEAT_DELAY`, 8: cycles from a press to the first repeat pulse (≥1); used only with repeat compiled in.
- `REPEAT_PERIOD`, 4: cycles between subsequent repeat pulses (≥1); used only with repeat compiled in.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; clears all state immediately when low.
- `In`  input  N  raw button inputs, asynchronous to `clk`.
- `level`  output  N  debounced button state.
- `press`  output  N  one-cycle pulse per accepted press (and repeat, if enabled).
- `last_idx`  output  max(1,$clog2(N))  index of the most recently pressed channel.
- `last_valid`  output  1  high once any press has occurred since reset.

## Operation

- Per channel: synchroniser chain of `SYNC_STAGES` flops; its last stage is `s[i]`.
- Debounce counter `cnt[i]`, width $clog2(DEBOUNCE_CYCLES+1), with two states per channel: STABLE (`s==level`) and PENDING (`s!=level`).
  - STABLE: `cnt` held at 0.
  - PENDING: `cnt` increments each edge; any edge seeing `s==level` returns `cnt` to 0 (glitch rejected).
  - When `cnt` would reach `DEBOUNCE_CYCLES`: `level[i]` <= `s[i]`, `cnt` <= 0.
- `press[i]` is registered: high for exactly the cycle following the edge where `level[i]` goes 0→1. Falling `level` produces no pulse.
- `last_idx`/`last_valid`: on any edge that sets one or more `press` bits, `last_idx` <= lowest-numbered pressing channel and `last_valid` <= 1. No press leaves both unchanged. Only reset clears them.
- Channels are fully independent apart from the `last_idx` arbitration.

## Timing

- Reset (low): all sync flops, `cnt`, `level`, `press`, `last_idx`, `last_valid`, and repeat counters are cleared to 0 asynchronously.
- A button held through reset therefore debounces and presses normally after reset deasserts.
- Press latency: `In[i]` high and stable before edge 1 gives `level[i]` and `press[i]` high after edge `SYNC_STAGES+DEBOUNCE_CYCLES`. With defaults, this is after edge 6. `press` drops after edge 7.
- Release latency: identical count. `level` falls after edge `SYNC_STAGES+DEBOUNCE_CYCLES`.
- A pulse on `In` shorter than `DEBOUNCE_CYCLES` cycles, as seen at `s`, never changes `level`.
- Reset asserted mid-count discards the count. No pulse is emitted from a partial count.

## Configuration

- Macro `BUTTON_CONDITIONER_REPEAT_EN`.
- Defined: a per-channel repeat counter runs while `level[i]` is 1.
  - `REPEAT_DELAY` cycles after the initial `press[i]`, a further one-cycle `press[i]` is emitted.
  - After that, a pulse is emitted every `REPEAT_PERIOD` cycles until `level[i]` falls. The counter clears on fall.
  - Repeat pulses update `last_idx` like initial presses.
- Undefined: no repeat counter logic. `REPEAT_DELAY`/`REPEAT_PERIOD` are accepted but ignored. `press` fires only on debounced rising edges.

## Test plan

- Clean press (defaults): reset low 2 cycles, then release reset; `In`=4'b0001 held → `level[0]`, `press[0]`, `last_idx`=0, `last_valid`=1 after edge 6; `press[0]` low after edge 7; `level` stays 1.
- Bounce rejection: `In[2]` high for 3 cycles, then low → `level[2]`=0 and `press`=0 throughout; `In[2]` then held 10 cycles → a single press.
- Release: from held `level[1]`=1, drop `In[1]` → `level[1]`=0 after 6 edges; no `press` pulse; `last_idx` unchanged.
- Simultaneous press: `In` 0→4'b1010 on the same cycle → `press`=4'b1010 for one cycle; `last_idx`=1.
- Reset mid-operation: `In[3]` high, reset pulsed low after edge 4 → all outputs 0 immediately; after release, the press appears 6 edges later.
- Repeat (macro defined): `In[0]` held 40 cycles → pulses at initial edge E, E+8, E+12, E+16, …; none after `level[0]` falls. Macro undefined: only the pulse at E.
